// File: rtl/tick_irq_ctrl_if.sv
// Processor port-I/O bus plus interrupt handshake for tick_irq_ctrl.
// Latency: none, wires only.
// Backpressure: none; single-cycle strobes, no flow control on this bus.
// Signals: port_id/out_port/write_strobe (write side), in_port (read data),
//          interrupt/interrupt_ack (level request and one-cycle acknowledge).
interface tick_irq_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  // Processor side drives address, write data and acknowledge.
  modport master (
    output port_id,
    output out_port,
    output write_strobe,
    output interrupt_ack,
    input  in_port,
    input  interrupt
  );

  // Peripheral side returns read data and the interrupt request.
  modport slave (
    input  port_id,
    input  out_port,
    input  write_strobe,
    input  interrupt_ack,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/tick_irq_ctrl.sv
// Periodic interrupt controller: prescaler tick every DIV clocks, event every PERIOD+1 ticks.
// Latency: register writes take effect on the write edge; interrupt rises one cycle after the event tick.
// Backpressure: none; the interrupt level is held until interrupt_ack, extra events set sticky OVR.
// Ports: clk_in, reset (async active-low), bus (slave: port I/O + interrupt), tick_out.
// Registers at BASE_ADDR+0..3: CTRL (EN, OVR_CLR), PERIOD, STATUS (EN, PEND, OVR), COUNT.
module tick_irq_ctrl #(
  parameter int          DIV       = 1000,
  parameter logic [7:0]  BASE_ADDR = 8'h00
) (
  input  logic           clk_in,
  input  logic           reset,
  tick_irq_ctrl_if.slave bus,
  output logic           tick_out
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} irq_state_t;

  localparam logic [9:0] DIV_LAST = 10'(DIV - 1);

  logic       en;
  logic [7:0] period;
  logic [9:0] presc;
  logic [7:0] count;
  logic       ovr;
  logic       ovr_nxt;
  irq_state_t state;
  irq_state_t state_nxt;

  // Address decode: wrap-around subtraction so the window is BASE_ADDR..BASE_ADDR+3.
  logic [7:0] offset;
  logic       hit;
  logic       wr_ctrl;
  logic       wr_period;
  logic       dis_wr;
  logic       ovr_clr;
  logic       tick;
  logic       period_evt;

  assign offset    = bus.port_id - BASE_ADDR;
  assign hit       = (offset[7:2] == 6'd0);
  assign wr_ctrl   = bus.write_strobe && hit && (offset[1:0] == 2'd0);
  assign wr_period = bus.write_strobe && hit && (offset[1:0] == 2'd1);
  assign dis_wr    = wr_ctrl && !bus.out_port[0];
  assign ovr_clr   = wr_ctrl && bus.out_port[1];

  assign tick       = en && (presc == DIV_LAST);
  assign period_evt = tick && (count == period);
  assign tick_out   = tick;

  // Configuration, prescaler and event counter.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      period <= 8'hFF;
      presc  <= 10'd0;
      count  <= 8'd0;
    end else begin
      if (wr_ctrl) en <= bus.out_port[0];
      if (wr_period) period <= bus.out_port;

      // Disable clears the prescaler; enabling from 0 starts from the held 0.
      if (dis_wr || !en || tick) presc <= 10'd0;
      else                       presc <= presc + 10'd1;

      // Any PERIOD write or disable restarts the count, even on a tick edge.
      if (dis_wr || wr_period) count <= 8'd0;
      else if (tick)           count <= period_evt ? 8'd0 : count + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ovr   <= ovr_nxt;
    end
  end

  // Pending interrupt: an event arriving with an ack in the same cycle is kept
  // as the new pending request and is not counted as an overrun.
  always_comb begin
    state_nxt = state;
    ovr_nxt   = ovr;
    if (ovr_clr) ovr_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (period_evt) state_nxt = PEND;
      end
      PEND: begin
        if (period_evt && !bus.interrupt_ack) ovr_nxt = 1'b1;
        else if (bus.interrupt_ack && !period_evt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.interrupt = (state == PEND);

  always_comb begin
    bus.in_port = 8'h00;
    if (hit) begin
      case (offset[1:0])
        2'd0: bus.in_port = {7'd0, en};
        2'd1: bus.in_port = period;
        2'd2: bus.in_port = {5'd0, ovr, (state == PEND), en};
        2'd3: bus.in_port = count;
        default: bus.in_port = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_irq_ctrl.sv
// Self-checking bench for tick_irq_ctrl with DIV=4 at BASE_ADDR=0.
// Directed scenarios followed by random register traffic and acks, checked
// every cycle against a reference model built from tick/event arithmetic.
module tb_tick_irq_ctrl;
  localparam int DIV = 4;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic tick_out;

  tick_irq_ctrl_if bus ();

  tick_irq_ctrl #(.DIV(DIV), .BASE_ADDR(8'h00)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .bus      (bus.slave),
    .tick_out (tick_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed enabled cycles and ticks since the last count clear.
  bit m_en;
  int m_period;
  bit m_pend;
  bit m_ovr;
  int m_ecyc;
  int m_nt;

  function automatic bit m_tick();
    return m_en && ((m_ecyc % DIV) == DIV - 1);
  endfunction

  function automatic int m_count();
    return m_nt % (m_period + 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] pid);
    case (pid)
      8'd0:    return {7'd0, m_en};
      8'd1:    return 8'(m_period);
      8'd2:    return {5'd0, m_ovr, m_pend, m_en};
      8'd3:    return 8'(m_count());
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_period = 255; m_pend = 0; m_ovr = 0; m_ecyc = 0; m_nt = 0;
  endtask

  task automatic m_advance(input logic [7:0] pid, input logic [7:0] dat, input bit ws, input bit ack);
    bit tk, ev, ovr_set;
    tk = m_tick();
    ev = tk && (m_count() == m_period);
    ovr_set = m_pend && ev && !ack;
    if (m_en) m_ecyc++;
    if (tk) m_nt++;
    if (!m_pend) m_pend = ev;
    else if (ovr_set) m_ovr = 1;
    else if (ack && !ev) m_pend = 0;
    if (ws && pid == 8'd0) begin
      if (!dat[0]) begin
        m_en = 0; m_ecyc = 0; m_nt = 0;
      end else if (!m_en) begin
        m_en = 1; m_ecyc = 0;
      end
      if (dat[1] && !ovr_set) m_ovr = 0;
    end
    if (ws && pid == 8'd1) begin
      m_period = int'(dat);
      m_nt = 0;
    end
  endtask

  // One clock cycle: drive after the falling edge, compare, advance the model.
  task automatic step(input logic [7:0] pid, input logic [7:0] dat, input bit ws, input bit ack);
    bus.port_id = pid; bus.out_port = dat; bus.write_strobe = ws; bus.interrupt_ack = ack;
    #1;
    check_eq("tick", tick_out, m_tick());
    check_eq("irq", bus.interrupt, m_pend);
    check_eq("rd", bus.in_port, m_read(pid));
    m_advance(pid, dat, ws, ack);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n, input logic [7:0] pid);
    for (int i = 0; i < n; i++) step(pid, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic peek(input logic [7:0] pid);
    bus.port_id = pid; bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0; bus.out_port = 8'h00;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b0;
    m_reset();
    #1;
    check_eq("rst_irq", bus.interrupt, 1'b0);
    check_eq("rst_tick", tick_out, 1'b0);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    bus.port_id = 8'h00; bus.out_port = 8'h00; bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    m_reset();

    // Reset state and readback.
    do_reset();
    peek(8'd1); check_eq("rst_period", bus.in_port, 8'hFF);
    peek(8'd2); check_eq("rst_status", bus.in_port, 8'h00);
    peek(8'd5); check_eq("undecoded", bus.in_port, 8'h00);

    // Basic period: PERIOD=2, interrupt 12 cycles after the enable write edge.
    step(8'd1, 8'd2, 1'b1, 1'b0);
    step(8'd0, 8'd1, 1'b1, 1'b0);
    n = 0;
    while (!bus.interrupt && n < 40) begin step(8'd3, 8'h00, 1'b0, 1'b0); n++; end
    check_eq("first_irq_cycles", n, 12);
    step(8'd2, 8'h00, 1'b0, 1'b1);
    peek(8'd2); check_eq("ack_clears", bus.interrupt, 1'b0);
    n = 0;
    while (!bus.interrupt && n < 40) begin step(8'd3, 8'h00, 1'b0, 1'b0); n++; end
    check_eq("next_irq_cycles", n, 11);

    // Overrun with PERIOD=0 and no ack, then clear OVR.
    do_reset();
    step(8'd1, 8'd0, 1'b1, 1'b0);
    step(8'd0, 8'd1, 1'b1, 1'b0);
    idle(9, 8'd2);
    peek(8'd2); check_eq("ovr_status", bus.in_port, 8'h07);
    step(8'd0, 8'h03, 1'b1, 1'b0);
    peek(8'd2); check_eq("ovr_cleared", bus.in_port, 8'h03);

    // Ack coinciding with an event keeps PEND and does not set OVR.
    do_reset();
    step(8'd1, 8'd0, 1'b1, 1'b0);
    step(8'd0, 8'd1, 1'b1, 1'b0);
    idle(7, 8'd2);
    peek(8'd2); check_eq("coll_is_tick", tick_out, 1'b1);
    step(8'd2, 8'h00, 1'b0, 1'b1);
    peek(8'd2); check_eq("coll_status", bus.in_port, 8'h03);

    // Disable mid-count with an interrupt pending.
    do_reset();
    step(8'd1, 8'd0, 1'b1, 1'b0);
    step(8'd0, 8'd1, 1'b1, 1'b0);
    idle(4, 8'd3);
    step(8'd1, 8'd5, 1'b1, 1'b0);
    idle(11, 8'd3);
    peek(8'd3); check_eq("count_before_dis", bus.in_port, 8'd3);
    step(8'd0, 8'd0, 1'b1, 1'b0);
    peek(8'd3); check_eq("count_after_dis", bus.in_port, 8'd0);
    idle(8, 8'd2);
    peek(8'd2); check_eq("dis_pend_kept", bus.in_port, 8'h02);
    step(8'd2, 8'h00, 1'b0, 1'b1);
    peek(8'd2); check_eq("dis_pend_acked", bus.interrupt, 1'b0);

    // Asynchronous reset between edges while pending.
    do_reset();
    step(8'd1, 8'd0, 1'b1, 1'b0);
    step(8'd0, 8'd1, 1'b1, 1'b0);
    idle(6, 8'd2);
    peek(8'd2); check_eq("pre_async_irq", bus.interrupt, 1'b1);
    #1 reset = 1'b0;
    m_reset();
    #1;
    check_eq("async_irq", bus.interrupt, 1'b0);
    check_eq("async_status", bus.in_port, 8'h00);
    peek(8'd1); check_eq("async_period", bus.in_port, 8'hFF);
    @(negedge clk_in);
    reset = 1'b1;

    // Random register traffic and acks.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] pid, dat;
      bit ws, ack;
      pid = 8'($urandom_range(0, 7));
      ws  = ($urandom_range(0, 15) == 0);
      ack = ($urandom_range(0, 7) == 0);
      dat = 8'($urandom);
      if (ws && pid == 8'd0) dat[0] = ($urandom_range(0, 7) != 0);
      if (ws && pid == 8'd1 && $urandom_range(0, 3) != 0) dat = 8'($urandom_range(0, 3));
      step(pid, dat, ws, ack);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tick_irq_ctrl.md
Name: tick_irq_ctrl

Overview:
Programmable periodic-interrupt controller for the TrameBlaze processor. An internal prescaler produces a one-cycle tick every DIV clocks. An event counter counts ticks up to a software-programmed period. On each period match it raises a level interrupt, which is held until the processor acknowledges it. The block is configured and monitored through the processor's 8-bit port I/O bus.

Parameters:
DIV, 1000, prescaler division ratio: clk_in cycles per tick (range 2..1024).
BASE_ADDR, 8'h00, port_id of register 0. The block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
clk_in  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
port_id  input  8  processor I/O address
out_port  input  8  processor write data
write_strobe  input  1  one-cycle write qualifier
in_port  output  8  read data, combinational mux on port_id; 8'h00 when address not decoded
interrupt  output  1  level interrupt request to processor
interrupt_ack  input  1  one-cycle acknowledge from processor
tick_out  output  1  one-cycle prescaler tick, for observation and other consumers

Behaviour:
Register map (offset from BASE_ADDR):
- +0 CTRL (R/W):
  - bit0 EN.
  - bit1 OVR_CLR: write-1 clears OVR; always reads 0.
  - Other bits read 0.
- +1 PERIOD (R/W), 8 bits. Writing it also clears the event counter to 0 on the same edge.
- +2 STATUS (RO): bit0 EN, bit1 PEND (= interrupt), bit2 OVR. Other bits 0.
- +3 COUNT (RO): current event counter value.
- Writes to +2/+3 are ignored.

Reset (reset=0, async):
- EN=0, PERIOD=8'hFF, presc=0, count=0, PEND=0, OVR=0.
- Outputs: interrupt=0, tick_out=0, in_port follows mux.

Prescaler (10-bit presc):
- EN=0: presc held at 0, tick_out=0.
- EN=1: presc increments each cycle.
- tick_out=1 (combinational) when EN=1 and presc==DIV-1; presc wraps to 0 on that edge.
- First tick occurs DIV cycles after EN goes 1.

Event counter (8-bit count):
- Updates on tick only.
- If count==PERIOD: count<=0 and an event is generated. Otherwise count<=count+1.
- PERIOD=0 gives an event every tick. Event spacing is (PERIOD+1)*DIV cycles.

Interrupt FSM, states IDLE (interrupt=0) and PEND (interrupt=1):
- IDLE, event -> PEND. interrupt rises on the edge ending the event cycle (registered, 1-cycle latency).
- PEND, interrupt_ack and no event -> IDLE. interrupt low on the next cycle.
- PEND, event and no interrupt_ack -> stay PEND, OVR<=1.
- PEND, event and interrupt_ack in the same cycle -> stay PEND. OVR unchanged; the new event is retained.
- IDLE, interrupt_ack -> ignored.

Other rules:
- OVR is sticky. It clears only on a CTRL write with bit1=1 or on reset. If the clear and a new overrun coincide, set wins.
- Writing EN=0: presc and count clear to 0 on that edge. PEND and OVR are unaffected; the pending interrupt still requires an ack.
- Writing EN=1 while already 1: no effect on presc or count.
- PERIOD written lower than the current count: count is cleared anyway, so there is no wrap through 255.
- Reset asserted mid-period or while PEND: everything returns to reset values immediately, with no clock edge needed.

Test Plan:
- Reset and readback (DIV=4, BASE=0): assert reset=0 -> interrupt=0, tick_out=0. Read port 1 -> 8'hFF, port 2 -> 8'h00, port 5 -> 8'h00.
- Basic period (DIV=4): write PERIOD=2, CTRL=1 -> tick_out every 4 cycles, first at cycle 4 after EN. interrupt rises 1 cycle after the 3rd tick (cycle 12 edge). Pulse interrupt_ack -> interrupt=0 next cycle. Next interrupt rises 12 cycles after the previous one.
- Overrun (DIV=4, PERIOD=0): enable and never ack -> interrupt stays 1, STATUS reads 8'h07 after the 2nd tick. Write CTRL=8'h03 -> STATUS=8'h03.
- Ack/event collision: PERIOD=0, DIV=4, assert interrupt_ack exactly on a tick cycle -> interrupt stays 1, OVR stays 0.
- Disable mid-count: PERIOD=5, read COUNT=3, write CTRL=0 -> COUNT=0 next cycle, tick_out stays 0, and an existing PEND stays 1 until acked.
- Async reset while PEND: drive reset=0 between clock edges -> interrupt falls immediately, STATUS=8'h00, PERIOD=8'hFF.
